counter_sweep_ctrl: RTL and testbench

Sequencer for the shared 4-bit up/down Counter. On a `start` request it programs the counter's terminal value and drives `count_inc`/`count_dec` to sweep the count 0 → limit → 0 a configured number of times, dwelling at each end. It observes the counter's `flag_count_max`/`flag_count_min` for handshaking and runs a watchdog so a stuck counter raises `error` rather than hanging. It sits between the host/test control logic and the Counter instance, and is the only driver of the Counter's control inputs.

---
 rtl/counter_sweep_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
// Sequencer that drives a shared up/down counter through repeated sweeps
// 0 -> limit -> 0, dwelling at each end. A watchdog turns a counter that
// never raises the expected flag into a sticky error state instead of a hang.
// This block is the only driver of the counter's load/inc/dec inputs.

module counter_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int REP_W   = 4,
    parameter int DWELL   = 2,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic             flag_count_max,
    input  logic             flag_count_min,
    output logic [WIDTH-1:0] count_to,
    output logic             load_en,
    output logic             count_inc,
    output logic             count_dec,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [REP_W-1:0] sweep_cnt
);

    // Watchdog must be able to hold TIMEOUT-1; dwell timer must hold DWELL-1.
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_UP       = 3'd2,
        ST_DWELL_HI = 3'd3,
        ST_DOWN     = 3'd4,
        ST_DWELL_LO = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERR      = 3'd7
    } state_t;

    // A repetition request of zero still performs one sweep.
    function automatic logic [REP_W-1:0] norm_reps(input logic [REP_W-1:0] reps);
        logic [REP_W-1:0] result;
        if (reps == {REP_W{1'b0}}) begin
            result = {{(REP_W-1){1'b0}}, 1'b1};
        end else begin
            result = reps;
        end
        return result;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] count_to_r;
    logic [REP_W-1:0] reps_r;
    logic [REP_W-1:0] sweep_cnt_r;
    logic [WD_W-1:0]  wd_r;
    logic [DW_W-1:0]  dwell_r;

    logic             accept_s;
    logic             in_run_s;
    logic             in_dwell_s;
    logic             sweep_end_s;
    logic [REP_W-1:0] sweep_next_s;
    logic             last_sweep_s;
    logic             wd_expired_s;
    logic             dwell_over_s;

    logic             load_en_s;
    logic             count_inc_s;
    logic             count_dec_s;
    logic             done_s;
    logic             busy_s;
    logic             error_s;

    // A start is only taken from a quiescent state, and abort always beats it.
    assign accept_s     = start && !abort && ((state_r == ST_IDLE) || (state_r == ST_ERR));
    assign in_run_s     = (state_r == ST_UP) || (state_r == ST_DOWN);
    assign in_dwell_s   = (state_r == ST_DWELL_HI) || (state_r == ST_DWELL_LO);
    assign sweep_end_s  = (state_r == ST_DOWN) && flag_count_min && !abort;
    assign sweep_next_s = sweep_cnt_r + {{(REP_W-1){1'b0}}, 1'b1};
    assign last_sweep_s = (sweep_next_s == reps_r);
    assign wd_expired_s = (wd_r == WD_LAST);
    assign dwell_over_s = (dwell_r == DW_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_s = ST_UP;
                end
                ST_UP: begin
                    if (flag_count_max) begin
                        state_s = ST_DWELL_HI;
                    end else if (wd_expired_s) begin
                        state_s = ST_ERR;
                    end else begin
                        state_s = ST_UP;
                    end
                end
                ST_DWELL_HI: begin
                    if (dwell_over_s) begin
                        state_s = ST_DOWN;
                    end else begin
                        state_s = ST_DWELL_HI;
                    end
                end
                ST_DOWN: begin
                    if (flag_count_min) begin
                        if (last_sweep_s) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_DWELL_LO;
                        end
                    end else if (wd_expired_s) begin
                        state_s = ST_ERR;
                    end else begin
                        state_s = ST_DOWN;
                    end
                end
                ST_DWELL_LO: begin
                    if (dwell_over_s) begin
                        state_s = ST_UP;
                    end else begin
                        state_s = ST_DWELL_LO;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                ST_ERR: begin
                    if (start) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_ERR;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode; counter controls and done are gated by abort in the same cycle.
    always_comb begin
        load_en_s   = 1'b0;
        count_inc_s = 1'b0;
        count_dec_s = 1'b0;
        done_s      = 1'b0;
        busy_s      = (state_r != ST_IDLE) && (state_r != ST_ERR);
        error_s     = (state_r == ST_ERR);
        if (abort) begin
            load_en_s   = 1'b0;
            count_inc_s = 1'b0;
            count_dec_s = 1'b0;
            done_s      = 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    load_en_s = 1'b1;
                end
                ST_UP: begin
                    count_inc_s = !flag_count_max;
                end
                ST_DOWN: begin
                    count_dec_s = !flag_count_min;
                end
                ST_DONE: begin
                    done_s = 1'b1;
                end
                default: begin
                    load_en_s = 1'b0;
                end
            endcase
        end
    end

    // Run configuration and sweep counter: latched on accepted start, held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_to_r  <= {WIDTH{1'b0}};
            reps_r      <= {REP_W{1'b0}};
            sweep_cnt_r <= {REP_W{1'b0}};
        end else if (accept_s) begin
            count_to_r  <= cfg_limit;
            reps_r      <= norm_reps(cfg_reps);
            sweep_cnt_r <= {REP_W{1'b0}};
        end else if (sweep_end_s) begin
            sweep_cnt_r <= sweep_next_s;
        end else begin
            sweep_cnt_r <= sweep_cnt_r;
        end
    end

    // Watchdog: counts cycles spent in UP/DOWN; zero in every other state so
    // each UP or DOWN phase starts from a cleared count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_r <= {WD_W{1'b0}};
        end else if (in_run_s) begin
            wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            wd_r <= {WD_W{1'b0}};
        end
    end

    // Dwell timer: counts cycles in either dwell state, cleared elsewhere.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell_r <= {DW_W{1'b0}};
        end else if (in_dwell_s) begin
            dwell_r <= dwell_r + {{(DW_W-1){1'b0}}, 1'b1};
        end else begin
            dwell_r <= {DW_W{1'b0}};
        end
    end

    assign count_to  = count_to_r;
    assign sweep_cnt = sweep_cnt_r;
    assign load_en   = load_en_s;
    assign count_inc = count_inc_s;
    assign count_dec = count_dec_s;
    assign done      = done_s;
    assign busy      = busy_s;
    assign error     = error_s;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Scoreboard bench for counter_sweep_ctrl: a behavioural 4-bit counter closes
// the flag loop; stimulus pushes expected events, a negedge monitor pops them.

module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] cfg_limit = 4'd0;
    logic [3:0] cfg_reps = 4'd0;
    logic       flag_count_max;
    logic       flag_count_min;
    logic [3:0] count_to;
    logic       load_en, count_inc, count_dec, busy, done, error;
    logic [3:0] sweep_cnt;

    counter_sweep_ctrl #(.WIDTH(4), .REP_W(4), .DWELL(2), .TIMEOUT(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_limit(cfg_limit), .cfg_reps(cfg_reps),
        .flag_count_max(flag_count_max), .flag_count_min(flag_count_min),
        .count_to(count_to), .load_en(load_en), .count_inc(count_inc),
        .count_dec(count_dec), .busy(busy), .done(done), .error(error),
        .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural counter
    logic [3:0] m_cnt = 4'd0;
    logic [3:0] m_lim = 4'd0;
    logic       stuck = 1'b0;
    logic       model_clr = 1'b1;

    always @(posedge clk) begin
        if (model_clr) begin
            m_cnt <= 4'd0;
        end else begin
            if (load_en) m_lim <= count_to;
            if (count_inc) m_cnt <= m_cnt + 4'd1;
            else if (count_dec) m_cnt <= m_cnt - 4'd1;
        end
    end
    assign flag_count_max = !stuck && (m_cnt == m_lim);
    assign flag_count_min = !stuck && (m_cnt == 4'd0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int EV_LOAD = 0, EV_SWEEP = 1, EV_DONE = 2, EV_ERR = 3;
    typedef struct { int kind; int a; int b; int c; int d; } ev_t;
    ev_t sb[$];

    int checks = 0;
    int errors = 0;
    int excl_bad = 0;

    function automatic string kname(input int k);
        case (k)
            EV_LOAD:  return "LOAD";
            EV_SWEEP: return "SWEEP";
            EV_DONE:  return "DONE";
            EV_ERR:   return "ERR";
            default:  return "UNKNOWN";
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int a, input int b, input int c, input int d);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c; e.d = d;
        sb.push_back(e);
    endtask

    // Pop the oldest expected event and compare it with what the DUT showed.
    task automatic take(input int k, input int a, input int b, input int c, input int d);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got a=%0d b=%0d c=%0d d=%0d required no event",
                     kname(k), a, b, c, d);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.a != a || e.b != b || e.c != c || e.d != d) begin
                errors++;
                $display("FAIL ev_%s: got %s a=%0d b=%0d c=%0d d=%0d required %s a=%0d b=%0d c=%0d d=%0d",
                         kname(e.kind), kname(k), a, b, c, d, kname(e.kind), e.a, e.b, e.c, e.d);
            end
        end
    endtask

    // Monitor
    initial begin
        int inc_n, dec_n;
        logic prev_err;
        logic [3:0] prev_sweep;
        inc_n = 0; dec_n = 0; prev_err = 1'b0; prev_sweep = 4'd0;
        forever begin
            @(negedge clk);
            if ((count_inc && count_dec) || (load_en && (count_inc || count_dec))) excl_bad++;
            if (count_inc) inc_n++;
            if (count_dec) dec_n++;
            if (error && !prev_err) take(EV_ERR, inc_n, int'(count_inc), int'(busy), cyc);
            if (load_en) begin
                take(EV_LOAD, int'(count_to), cyc, int'(error), int'(busy));
                inc_n = 0;
                dec_n = 0;
            end
            if (sweep_cnt != prev_sweep && sweep_cnt != 4'd0) take(EV_SWEEP, int'(sweep_cnt), 0, 0, 0);
            if (done) take(EV_DONE, int'(sweep_cnt), inc_n, dec_n, cyc);
            prev_err = error;
            prev_sweep = sweep_cnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start now; the next edge samples it and LOAD follows in that cycle.
    task automatic go(input int l, input int r, output int n0);
        n0 = cyc;
        cfg_limit = 4'(l);
        cfg_reps = 4'(r);
        start = 1'b1;
        push(EV_LOAD, l, n0 + 1, 0, 1);
        tick();
        start = 1'b0;
    endtask

    task automatic expect_done(input int n0, input int reps_eff, input int pulses, input int off);
        for (int s = 1; s <= reps_eff; s++) push(EV_SWEEP, s, 0, 0, 0);
        push(EV_DONE, reps_eff, pulses, pulses, n0 + off);
    endtask

    task automatic drain(input int budget, input string name);
        int i;
        i = 0;
        while (sb.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        check(name, sb.size(), 0);
        sb.delete();
        tick();
    endtask

    // Directed vectors: limit, reps, effective reps, inc pulses per run, done offset
    typedef struct { int l; int r; int re; int pulses; int off; } vec_t;
    vec_t vecs[3] = '{
        '{l: 15, r: 3, re: 3, pulses: 45, off: 108},
        '{l: 0,  r: 0, re: 1, pulses: 0,  off: 6},
        '{l: 2,  r: 2, re: 2, pulses: 4,  off: 20}
    };

    initial begin
        int n;
        // Reset values
        #2;
        check("reset_ctrl", int'({load_en, count_inc, count_dec, busy, done, error}), 0);
        check("reset_count_to", int'(count_to), 0);
        check("reset_sweep_cnt", int'(sweep_cnt), 0);
        tick(); tick();
        reset_n = 1'b1;
        model_clr = 1'b0;
        tick();

        // L=5 reps=1, with a start while busy that must be ignored
        go(5, 1, n);
        expect_done(n, 1, 5, 16);
        repeat (4) tick();
        cfg_limit = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_count_to", int'(count_to), 5);
        drain(40, "l5_drain");
        check("l5_busy_after", int'(busy), 0);
        check("l5_sweep_hold", int'(sweep_cnt), 1);

        // Table runs
        foreach (vecs[i]) begin
            go(vecs[i].l, vecs[i].r, n);
            expect_done(n, vecs[i].re, vecs[i].pulses, vecs[i].off);
            drain(200, "vec_drain");
            check("vec_busy_after", int'(busy), 0);
        end

        // Start and abort together in IDLE: stays idle, no load
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", int'(busy), 0);
        tick();

        // Abort during DOWN of sweep 2
        go(3, 3, n);
        push(EV_SWEEP, 1, 0, 0, 0);
        while (cyc < n + 21) tick();
        check("dec_before_abort", int'(count_dec), 1);
        abort = 1'b1;
        #1;
        check("abort_gates_dec", int'(count_dec), 0);
        tick();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_sweep_held", int'(sweep_cnt), 1);
        repeat (3) tick();
        check("abort_events", sb.size(), 0);
        sb.delete();
        model_clr = 1'b1;
        tick();
        model_clr = 1'b0;

        // Asynchronous reset in the middle of UP
        go(15, 1, n);
        while (cyc < n + 6) tick();
        check("inc_before_reset", int'(count_inc), 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_ctrl", int'({load_en, count_inc, count_dec, busy, done, error}), 0);
        check("async_reset_sweep", int'(sweep_cnt), 0);
        tick(); tick();
        reset_n = 1'b1;
        model_clr = 1'b1;
        tick();
        model_clr = 1'b0;
        tick();
        check("busy_after_reset", int'(busy), 0);
        check("reset_queue", sb.size(), 0);
        sb.delete();

        // Stuck counter: watchdog error after 32 cycles in UP, then recovery
        stuck = 1'b1;
        go(5, 1, n);
        push(EV_ERR, 32, 0, 0, n + 34);
        drain(60, "stuck_drain");
        check("error_held", int'(error), 1);
        check("err_inc_low", int'(count_inc), 0);
        stuck = 1'b0;
        model_clr = 1'b1;
        tick();
        model_clr = 1'b0;
        go(5, 1, n);
        expect_done(n, 1, 5, 16);
        drain(40, "recover_drain");
        check("recover_error", int'(error), 0);

        check("exclusive_controls", excl_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
